// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit-type encodings,
// port indices and the output-buffer write-side state.
package noc_pkg;

  localparam int FT_W = 2;

  localparam logic [FT_W-1:0] FLIT_SINGLE = 2'b00;
  localparam logic [FT_W-1:0] FLIT_HEAD   = 2'b01;
  localparam logic [FT_W-1:0] FLIT_BODY   = 2'b10;
  localparam logic [FT_W-1:0] FLIT_TAIL   = 2'b11;

  localparam int PORT_L    = 0;
  localparam int PORT_N    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_S    = 4;
  localparam int NUM_PORTS = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } wr_state_e;

endpackage

// File: rtl/outport_fifo_mem.sv
// Flit storage for the output buffer: synchronous write,
// asynchronous read so the head flit falls through.
module outport_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/outport_buffer.sv
// Output-side flit FIFO for one router direction with
// registered ready, packet framing checks and overflow flag.
module outport_buffer
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int READY_MARGIN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     ready_out,
  output logic                     tx_valid,
  output logic [DATA_WIDTH-1:0]    tx_data,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_active,
  output logic                     overflow,
  output logic                     proto_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  RDY_MAX = CNT_W'(DEPTH - 1 - READY_MARGIN);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q;
  logic              ovf_q, ovf_d;
  logic              perr_q, perr_d;
  wr_state_e         state_q, state_d;

  logic            full;
  logic            push;
  logic            pop;
  logic [FT_W-1:0] ftype;

  assign full  = (count_q == FULL_C);
  assign push  = wr_en & ~full;
  assign pop   = tx_valid & tx_ready;
  assign ftype = wr_data[DATA_WIDTH-1 -: FT_W];

  outport_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (tx_data)
  );

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Framing only advances on accepted flits; dropped writes are ignored.
  always_comb begin
    state_d = state_q;
    perr_d  = perr_q;
    ovf_d   = ovf_q | (wr_en & full);
    if (push) begin
      unique case (state_q)
        S_IDLE: begin
          if (ftype == FLIT_HEAD) state_d = S_PKT;
          else if (ftype != FLIT_SINGLE) perr_d = 1'b1;
        end
        S_PKT: begin
          if (ftype == FLIT_TAIL) state_d = S_IDLE;
          else if (ftype != FLIT_BODY) perr_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d <= RDY_MAX);
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      state_q  <= state_d;
    end
  end

  assign tx_valid   = (count_q != '0);
  assign count      = count_q;
  assign ready_out  = ready_q;
  assign pkt_active = (state_q == S_PKT);
  assign overflow   = ovf_q;
  assign proto_err  = perr_q;

endmodule
